// File: rtl/debouncer_bank_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
package debouncer_bank_pkg;

    // Which transition of the clean level produces an edge pulse.
    localparam logic DETECT_FALL = 1'b0;
    localparam logic DETECT_RISE = 1'b1;

    // Active level of the edge outputs.
    localparam logic MODE_NEG = 1'b0;
    localparam logic MODE_POS = 1'b1;

    // Stability counter width: wide enough to hold the value delay.
    function automatic int cnt_width(input int delay);
        return $clog2(delay + 1);
    endfunction

endpackage

// File: rtl/debouncer_bank_channel.sv
// One debouncer channel: two-flop synchroniser, stability counter,
// clean level and a registered edge pulse.
module debounce_channel
    import debouncer_bank_pkg::*;
#(
    parameter int   delay  = 5,
    parameter logic detect = DETECT_RISE,
    parameter logic mode   = MODE_POS
) (
    input  logic ck,
    input  logic rst_n,
    input  logic x,
    output logic z,
    output logic e
);

    localparam int             CW     = cnt_width(delay);
    localparam logic [CW-1:0]  LAST   = CW'(delay - 1);
    localparam logic [CW-1:0]  ONE    = CW'(1);
    localparam logic [CW-1:0]  ZERO   = CW'(0);
    localparam logic           ACTIVE = mode;
    localparam logic           IDLE   = ~mode;

    logic          s1;
    logic          s;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          z_next;
    logic          e_next;

    // Next counter / level / pulse values from the current synchronised sample.
    always_comb begin
        cnt_next = cnt;
        z_next   = z;
        e_next   = IDLE;
        if (s == z) begin
            // Any agreeing sample throws away the partial count.
            cnt_next = ZERO;
        end else if (cnt == LAST) begin
            // delay consecutive disagreeing samples: accept the change.
            cnt_next = ZERO;
            z_next   = s;
            if (s == detect) begin
                e_next = ACTIVE;
            end else begin
                e_next = IDLE;
            end
        end else begin
            cnt_next = cnt + ONE;
        end
    end

    // Synchroniser, counter and outputs; reset discards any pending count.
    always_ff @(posedge ck) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            s   <= 1'b0;
            cnt <= ZERO;
            z   <= 1'b0;
            e   <= IDLE;
        end else begin
            s1  <= x;
            s   <= s1;
            cnt <= cnt_next;
            z   <= z_next;
            e   <= e_next;
        end
    end

endmodule

// File: rtl/debouncer_bank.sv
// Bank of n independent debouncer channels with a combined edge indicator.
module debouncer_bank
    import debouncer_bank_pkg::*;
#(
    parameter int   n      = 4,
    parameter int   delay  = 5,
    parameter logic detect = DETECT_RISE,
    parameter logic mode   = MODE_POS
) (
    input  logic         ck,
    input  logic         rst_n,
    input  logic [n-1:0] x,
    output logic [n-1:0] z,
    output logic [n-1:0] e,
    output logic         any_e
);

    genvar i;
    generate
        for (i = 0; i < n; i++) begin : g_ch
            debounce_channel #(
                .delay  (delay),
                .detect (detect),
                .mode   (mode)
            ) u_ch (
                .ck    (ck),
                .rst_n (rst_n),
                .x     (x[i]),
                .z     (z[i]),
                .e     (e[i])
            );
        end
    endgenerate

    // any_e is active when any channel pulse is active; the reduction
    // follows the active level so the idle value is the idle level.
    always_comb begin
        if (mode == MODE_POS) begin
            any_e = |e;
        end else begin
            any_e = &e;
        end
    end

endmodule

// File: doc/debouncer_bank.md
# debouncer_bank

Multi-channel debouncer with per-channel edge detection, generalising the single-bit counter debouncer to `n` channels. Each channel has its own input synchroniser, a stability counter with a configurable `delay`, a clean level output and a configurable edge pulse. The block sits between raw push-button or switch pins and synchronous control logic, replacing separate debouncer and edge-detector instances.

## Interface
- `n`, 4: number of independent channels, ≥1.
- `delay`, 5: consecutive stable cycles required before a change is accepted, ≥1.
- `detect`, 1: 1 = rising edge of the clean level, 0 = falling edge.
- `mode`, 1: 1 = edge output idles at 0 and pulses 1; 0 = edge output idles at 1 and pulses 0.
- `ck`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `x`  in  n  raw asynchronous noisy inputs, one bit per channel.
- `z`  out  n  debounced clean level per channel.
- `e`  out  n  edge pulse per channel, polarity set by `detect`/`mode`.
- `any_e`  out  1  asserted (active level per `mode`) when any `e` bit is at its active level.

## Operation
- **Per channel synchroniser.** Two flops, `x → s1 → s`; `s` is the synchronised input.
- **Per channel counter.** `cnt` is `$clog2(delay+1)` bits wide, unsigned. Each cycle:
  - If `s == z`: `cnt <= 0`.
  - Else if `cnt == delay-1`: `z <= s` and `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
- **Glitch rejection.** Any sample with `s == z` before the count completes clears `cnt`. `z` is unchanged. No partial credit is kept.
- **Edge pulse.** `e[i]` is registered and is at its active level for exactly the one cycle in which `z[i]` holds its new value.
  - The pulse fires only if the change matches `detect`: 0→1 when `detect`=1, 1→0 when `detect`=0.
  - Changes in the other direction produce no pulse.
- **Polarity.** Active level of `e` and `any_e` is 1 when `mode`=1 and 0 when `mode`=0.
- **`any_e`.** Combinational reduction of `e`: OR of `e` for `mode`=1, AND of `e` for `mode`=0.
- **Channel independence.** Channels are fully independent; simultaneous changes on several channels are each handled in parallel with identical timing.
- **Reset values (after a clock edge with `rst_n`=0):**
  - `s1`, `s`, `cnt` and `z` are all 0.
  - `e` is all 0 when `mode`=1 and all 1 when `mode`=0.
  - `any_e` is at its idle level.
- **Reset mid-count.** Pending counts are discarded. No edge pulse is generated by reset itself.
- **First cycle after reset release.** Inputs held at 1 through reset debounce normally: `z` rises after the standard latency and a rising pulse fires if `detect`=1.
- **`delay`=1.** `z` follows `s` with one cycle of lag; no filtering beyond the synchroniser.

## Timing
- **Edge naming.** Let clock edge k be the first edge that samples a new `x` value into `s1`.
  - `s` changes at edge k+1.
  - `z` changes at edge k+1+`delay`, provided `x` stays stable throughout.
- **Pulse timing.** `e` is at its active level for the single cycle following edge k+1+`delay`.
- **Input to output.** Latency from `x` change to `z` change is `delay`+2 cycles worst case.
- **Glitch threshold.** An `x` pulse shorter than `delay` full cycles, as seen at `s`, never reaches `z`.
- **Pulse rate.** Edge pulses on one channel are separated by at least 2·`delay` cycles, because a full opposite transition is needed in between.
- **Throughput.** No handshake; outputs are valid every cycle.

## Structure
- **Sub-module `debounce_channel`** holds one channel's synchroniser, counter, `z` and `e`, with parameters `delay`, `detect` and `mode`.
- **Top level** instantiates `n` copies in a generate loop and forms `any_e`.
- **Shared package/header:** constants `DETECT_FALL`=0, `DETECT_RISE`=1, `MODE_NEG`=0, `MODE_POS`=1, plus a `clog2`-based counter-width function.

## Test plan
- **Reset.** Hold `rst_n`=0 for 3 cycles with `x`=4'b1111 → `z`=0, `e`=0 and `any_e`=0 throughout. After release, `z` becomes 4'b1111 at edge k+6 (`delay`=5) and `e`=4'b1111 for one cycle.
- **Clean rise.** With `delay`=5, `detect`=1, `mode`=1, step `x[0]` 0→1 and hold → `z[0]` rises exactly 6 edges after the sampling edge. `e[0]` is 1 for one cycle; `any_e` matches.
- **Glitch.** Pulse `x[1]` high for 3 cycles, then low → `z[1]` and `e[1]` stay 0. Bounce `x[1]` 1-0-1 with a 1-cycle gap, then hold → the count restarts and `z[1]` rises `delay`+1 edges after the last 0→1 sample.
- **Wrong-direction edge.** With `detect`=1, make `x[2]` fall after it has settled high → `z[2]` falls and `e[2]` stays idle. Repeat with `detect`=0, `mode`=0 → `e[2]` is 1 idle, 0 for one cycle on the fall, and `any_e` pulses 0.
- **Simultaneous channels and mid-count reset.** Change `x[3:0]` together → all `z` bits change on the same edge. Assert `rst_n`=0 at `cnt`=3 → `cnt`=0, `z`=0, no pulse. Recheck behaviour with `delay`=1, 3, 7 and 12.
